replace_num_packet_rx: RTL
==========================

REPLACE_NUM_PACKET_RX -- requirements
Module: replace_num_packet_rx

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, the replacement-number address field width in bits.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, the replacement-number data field width in bits.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 100000, the maximum number of clk cycles allowed between accepted bytes of one message.
REQ-004 The block SHALL have parameter HEADER_BYTE, default 8'h52, the message start byte.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, a synchronous, active-high reset.
REQ-007 The block SHALL have port rx_data, input, 8 bits, the received UART byte, valid only when rx_valid=1.
REQ-008 The block SHALL have port rx_valid, input, 1 bit, a one-cycle strobe per received byte.
REQ-009 The block SHALL have port wr_packet, output, ADDR_WIDTH+DATA_WIDTH bits, equal to {address, data}, with the address in the MSBs.
REQ-010 The block SHALL have port wr_en, output, 1 bit, a one-cycle pulse qualifying wr_packet.
REQ-011 The block SHALL have port csum_err, output, 1 bit, a one-cycle pulse on checksum mismatch.
REQ-012 The block SHALL have port timeout_err, output, 1 bit, a one-cycle pulse on an inter-byte timeout.
REQ-013 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-014 Message format SHALL be: HEADER_BYTE, then N=(ADDR_WIDTH+DATA_WIDTH)/8 payload bytes sent MSB first, then one checksum byte equal to the XOR of all payload bytes.
REQ-015 ADDR_WIDTH+DATA_WIDTH SHALL be a multiple of 8; any other value SHALL be rejected at elaboration.
REQ-016 The state machine SHALL have three states: IDLE, PAYLOAD and CHECK.
REQ-017 In IDLE, rx_valid with rx_data==HEADER_BYTE SHALL clear the shift register, the byte counter and the running XOR, and move to PAYLOAD; any other byte SHALL be discarded and the state stays IDLE.
REQ-018 In PAYLOAD, each rx_valid SHALL shift rx_data into the LSB end of the shift register, XOR it into the running checksum and increment the byte counter; on the Nth byte the state SHALL move to CHECK.
REQ-019 A HEADER_BYTE value received in PAYLOAD SHALL be treated as payload data, not as a resynchronisation.
REQ-020 In CHECK, rx_valid with rx_data equal to the running XOR SHALL load wr_packet from the shift register and assert wr_en on the following cycle.
REQ-021 In CHECK, rx_valid with a mismatching rx_data SHALL pulse csum_err on the following cycle and leave wr_packet unchanged.
REQ-022 After the checksum byte, whether it matches or not, the state SHALL return to IDLE.
REQ-023 Latency SHALL be exactly one cycle from the checksum-byte rx_valid to wr_en.
REQ-024 wr_packet SHALL hold its last value until the next successful message.
REQ-025 wr_en SHALL never be high on two consecutive cycles; the downstream memory depends on an idle cycle between writes.
REQ-026 The timeout counter SHALL clear on every accepted byte and increment in each cycle in PAYLOAD or CHECK without rx_valid.
REQ-027 When the timeout counter reaches TIMEOUT_CYCLES, the block SHALL pulse timeout_err on the next cycle and return to IDLE, discarding the partial message.
REQ-028 If a timeout and an rx_valid occur in the same cycle, the byte SHALL take priority and the timeout counter SHALL clear.
REQ-029 The counter width SHALL be $clog2(TIMEOUT_CYCLES+1) and the counter SHALL saturate, never wrapping.
REQ-030 busy SHALL be high in PAYLOAD and CHECK and low in IDLE.

Reset
REQ-031 While reset=1 at a clk edge, the state SHALL become IDLE, and the byte counter, running XOR, timeout counter, wr_packet, wr_en, csum_err and timeout_err SHALL all become 0.
REQ-032 Reset SHALL take priority over rx_valid in the same cycle.
REQ-033 Reset asserted mid-message SHALL abort the message with no wr_en and no error pulse.
REQ-034 In the first cycle after reset deasserts, the block SHALL accept a header byte.

Verification
REQ-035 Send 52,00,10,AB,CD,76 (defaults) -> one wr_en pulse, one cycle after the 76 byte, with wr_packet=32'h0010ABCD.
REQ-036 Send 52,00,10,AB,CD,77 -> csum_err pulse, no wr_en, and wr_packet retains its previous value.
REQ-037 Send 52,00,10, then no byte for TIMEOUT_CYCLES cycles -> timeout_err pulse and busy=0, after which a full valid message is accepted normally.
REQ-038 Send 13,52,52,52,52,52,00 -> 13 ignored; payload 52525252 with XOR 00 -> wr_en with wr_packet=32'h52525252.
REQ-039 Assert reset after the third payload byte, then send a full valid message -> no write for the aborted message and exactly one correct write for the new one.
REQ-040 Send two valid messages back-to-back with rx_valid every cycle -> two wr_en pulses that are never adjacent, and no error pulses.

Source files
------------

// File: rtl/replace_num_packet_rx.sv
// UART packet receiver: header, MSB-first {address, data} payload, XOR checksum.
// Emits a one-cycle wr_en with the assembled packet, or an error pulse.
module replace_num_packet_rx #(
    parameter int          ADDR_WIDTH     = 16,
    parameter int          DATA_WIDTH     = 16,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  HEADER_BYTE    = 8'h52
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [7:0]                     rx_data,
    input  logic                           rx_valid,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] wr_packet,
    output logic                           wr_en,
    output logic                           csum_err,
    output logic                           timeout_err,
    output logic                           busy
);
    localparam int PW = ADDR_WIDTH + DATA_WIDTH;
    localparam int NB = PW / 8;
    localparam int CW = $clog2(NB + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES);

    generate
        if ((PW % 8) != 0) begin : g_bad_width
            $error("ADDR_WIDTH+DATA_WIDTH must be a multiple of 8");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   shreg_q, shreg_d;
    logic [PW-1:0]   pkt_q, pkt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      xor_q, xor_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            wr_en_q, wr_en_d;
    logic            csum_err_q, csum_err_d;
    logic            timeout_err_q, timeout_err_d;
    logic            hdr_seen;
    logic            tmo_hit;

    assign hdr_seen = rx_valid && (rx_data == HEADER_BYTE);
    assign tmo_hit  = (tmo_q == TMO_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            xor_q         <= '0;
            tmo_q         <= '0;
            pkt_q         <= '0;
            wr_en_q       <= 1'b0;
            csum_err_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            xor_q         <= xor_d;
            tmo_q         <= tmo_d;
            pkt_q         <= pkt_d;
            wr_en_q       <= wr_en_d;
            csum_err_q    <= csum_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // The shift register is cleared on every header, so it needs no reset.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hdr_seen) state_d = PAYLOAD;
            PAYLOAD: begin
                if (rx_valid) begin
                    if (cnt_q == LAST_BYTE) state_d = CHECK;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                end
            end
            CHECK:   if (rx_valid || tmo_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shreg_d       = shreg_q;
        pkt_d         = pkt_q;
        cnt_d         = cnt_q;
        xor_d         = xor_q;
        tmo_d         = tmo_q;
        wr_en_d       = 1'b0;
        csum_err_d    = 1'b0;
        timeout_err_d = 1'b0;
        if (state_q == IDLE) begin
            tmo_d = '0;
            if (hdr_seen) begin
                shreg_d = '0;
                cnt_d   = '0;
                xor_d   = '0;
            end
        end else begin
            // An arriving byte wins over a simultaneous timeout.
            if (rx_valid) begin
                tmo_d = '0;
            end else if (tmo_hit) begin
                tmo_d         = '0;
                timeout_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
            if (rx_valid && state_q == PAYLOAD) begin
                shreg_d = PW'({shreg_q, rx_data});
                xor_d   = xor_q ^ rx_data;
                cnt_d   = cnt_q + CW'(1);
            end
            if (rx_valid && state_q == CHECK) begin
                if (rx_data == xor_q) begin
                    pkt_d   = shreg_q;
                    wr_en_d = !wr_en_q;
                end else begin
                    csum_err_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy        = (state_q != IDLE);
        wr_packet   = pkt_q;
        wr_en       = wr_en_q;
        csum_err    = csum_err_q;
        timeout_err = timeout_err_q;
    end
endmodule
